// File: rtl/mram_access_sequencer.sv
// rtl/mram_access_sequencer.sv - word read/write sequencer in front of the MRAM SPI shift engine
// Builds WREN/WRITE/READ frames, runs the engine start/ready handshake and guards each frame with a watchdog.
module mram_access_sequencer #(
    parameter int          ADDR_W   = 16,
    parameter int          DATA_W   = 64,
    parameter int          FRAME_W  = 88,
    parameter int          TIMEOUT  = 4096,
    parameter logic [7:0]  OP_WREN  = 8'h06,
    parameter logic [7:0]  OP_WRITE = 8'h02,
    parameter logic [7:0]  OP_READ  = 8'h03
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_write_i,
    input  logic [ADDR_W-1:0]  req_addr_i,
    input  logic [DATA_W-1:0]  req_wdata_i,
    output logic               rsp_valid_o,
    output logic               rsp_error_o,
    output logic [DATA_W-1:0]  rsp_rdata_o,
    output logic [7:0]         err_count_o,
    output logic               spi_start_o,
    input  logic               spi_ready_i,
    output logic [7:0]         spi_num_of_bits_o,
    output logic [FRAME_W-1:0] spi_data_to_send_o,
    input  logic [FRAME_W-1:0] spi_data_received_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP_WREN,
        S_SETUP_CMD,
        S_ISSUE,
        S_BUSY,
        S_RESP
    } state_t;

    localparam logic [12:0] WDOG_LAST = 13'(TIMEOUT - 1);

    state_t              state_q;
    logic                write_q;
    logic                phase_q;
    logic                armed_q;
    logic [12:0]         wdog_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                rsp_valid_q;
    logic                rsp_error_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [7:0]          err_count_q;
    logic                spi_start_q;
    logic [7:0]          nbits_q;
    logic [FRAME_W-1:0]  frame_q;
    logic                unused_rx;

    assign req_ready_o        = (state_q == S_IDLE);
    assign rsp_valid_o        = rsp_valid_q;
    assign rsp_error_o        = rsp_error_q;
    assign rsp_rdata_o        = rsp_rdata_q;
    assign err_count_o        = err_count_q;
    assign spi_start_o        = spi_start_q;
    assign spi_num_of_bits_o  = nbits_q;
    assign spi_data_to_send_o = frame_q;
    assign unused_rx          = ^spi_data_received_i[FRAME_W-1:DATA_W];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            phase_q     <= 1'b0;
            armed_q     <= 1'b0;
            wdog_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            err_count_q <= '0;
            spi_start_q <= 1'b0;
            nbits_q     <= '0;
            frame_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        write_q <= req_write_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        phase_q <= req_write_i;
                        // Frame is loaded a cycle ahead of spi_start so the engine sees it settled.
                        if (req_write_i) begin
                            frame_q <= {{(FRAME_W-8){1'b0}}, OP_WREN};
                            nbits_q <= 8'd8;
                            state_q <= S_SETUP_WREN;
                        end else begin
                            frame_q <= {OP_READ, req_addr_i, {DATA_W{1'b0}}};
                            nbits_q <= 8'(FRAME_W);
                            state_q <= S_SETUP_CMD;
                        end
                    end
                end
                S_SETUP_WREN, S_SETUP_CMD: begin
                    spi_start_q <= 1'b1;
                    wdog_q      <= '0;
                    armed_q     <= spi_ready_i;
                    state_q     <= S_ISSUE;
                end
                S_ISSUE, S_BUSY: begin
                    if (wdog_q == WDOG_LAST) begin
                        spi_start_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b1;
                        if (err_count_q != 8'hFF) begin
                            err_count_q <= err_count_q + 8'd1;
                        end
                        state_q <= S_IDLE;
                    end else begin
                        wdog_q <= wdog_q + 13'd1;
                        if (state_q == S_ISSUE) begin
                            // A low ready only counts as acceptance once the engine was seen idle.
                            if (spi_ready_i) begin
                                armed_q <= 1'b1;
                            end else if (armed_q) begin
                                spi_start_q <= 1'b0;
                                state_q     <= S_BUSY;
                            end
                        end else if (spi_ready_i) begin
                            if (phase_q) begin
                                phase_q <= 1'b0;
                                frame_q <= {OP_WRITE, addr_q, wdata_q};
                                nbits_q <= 8'(FRAME_W);
                                state_q <= S_SETUP_CMD;
                            end else begin
                                if (!write_q) begin
                                    rsp_rdata_q <= spi_data_received_i[DATA_W-1:0];
                                end
                                rsp_valid_q <= 1'b1;
                                state_q     <= S_RESP;
                            end
                        end
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
